// File: rtl/priority_encoder_16_4_seq.sv
// Sequential 16->4 priority encoder: captures a request vector and emits
// pending indices lowest-first, one per handshake, tagging prime indices.
module priority_encoder_16_4_seq #(
  parameter logic [15:0] PRIME_MASK = 16'h28AC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        load,
  input  logic        out_ready,
  output logic [3:0]  code,
  output logic        out_valid,
  output logic        is_prime,
  output logic        busy,
  output logic        none,
  output logic [4:0]  count
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [15:0] pend, pend_nxt;
  logic        none_nxt;
  logic [3:0]  low_idx;
  logic [4:0]  pop;

  // Outputs come only from pend/state; pend is zero in IDLE so code/count idle at 0.
  always_comb begin
    low_idx = 4'd0;
    pop     = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pend[i]) low_idx = 4'(i);
    end
    for (int i = 0; i < 16; i++) begin
      pop = pop + 5'(pend[i]);
    end
  end

  assign out_valid = (state == EMIT);
  assign busy      = (state == EMIT);
  assign code      = low_idx;
  assign count     = pop;
  assign is_prime  = out_valid & PRIME_MASK[low_idx];

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    none_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          if (req != 16'h0000) begin
            pend_nxt  = req;
            state_nxt = EMIT;
          end else begin
            none_nxt = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          pend_nxt = pend & ~(16'h0001 << low_idx);
          if (pend_nxt == 16'h0000) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= 16'h0000;
      none  <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      none  <= none_nxt;
    end
  end

endmodule

// File: tb/tb_priority_encoder_16_4_seq.sv
// Directed bench for priority_encoder_16_4_seq; inputs driven and outputs
// checked on the falling edge.
module tb_priority_encoder_16_4_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        load;
  logic        out_ready;
  logic [3:0]  code;
  logic        out_valid;
  logic        is_prime;
  logic        busy;
  logic        none;
  logic [4:0]  count;

  int checks   = 0;
  int failures = 0;

  priority_encoder_16_4_seq dut (
    .clk(clk), .rst_n(rst_n), .req(req), .load(load), .out_ready(out_ready),
    .code(code), .out_valid(out_valid), .is_prime(is_prime), .busy(busy),
    .none(none), .count(count)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; req = 16'h0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, busy, none, is_prime, code, count} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b b=%b n=%b p=%b code=%0d cnt=%0d exp all 0",
               out_valid, busy, none, is_prime, code, count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, none, count} !== 8'd0) begin
      failures++;
      $display("FAIL idle_after_reset got v=%b b=%b n=%b cnt=%0d exp 0", out_valid, busy, none, count);
    end
  endtask

  task automatic test_single();
    load = 1'b1; req = 16'h0001; out_ready = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if ({out_valid, code, is_prime, count} !== {1'b1, 4'd0, 1'b0, 5'd1}) begin
      failures++;
      $display("FAIL single_emit got v=%b code=%0d p=%b cnt=%0d exp v=1 code=0 p=0 cnt=1",
               out_valid, code, is_prime, count);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL single_idle got v=%b b=%b exp 0 0", out_valid, busy);
    end
  endtask

  task automatic test_primes();
    logic [3:0] exp_code [6] = '{4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13};
    load = 1'b1; req = 16'h28AC; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      load = 1'b0;
      checks++;
      if ({out_valid, code, is_prime, count} !== {1'b1, exp_code[i], 1'b1, 5'(6 - i)}) begin
        failures++;
        $display("FAIL primes_step%0d got v=%b code=%0d p=%b cnt=%0d exp v=1 code=%0d p=1 cnt=%0d",
                 i, out_valid, code, is_prime, count, exp_code[i], 6 - i);
      end
    end
    @(negedge clk);
    checks++;
    if ({out_valid, busy, count} !== 7'd0) begin
      failures++;
      $display("FAIL primes_idle got v=%b b=%b cnt=%0d exp 0", out_valid, busy, count);
    end
  endtask

  task automatic test_stall();
    load = 1'b1; req = 16'h8001; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      load = 1'b0;
      checks++;
      if ({out_valid, code, is_prime, count} !== {1'b1, 4'd0, 1'b0, 5'd2}) begin
        failures++;
        $display("FAIL stall_hold%0d got v=%b code=%0d p=%b cnt=%0d exp v=1 code=0 p=0 cnt=2",
                 i, out_valid, code, is_prime, count);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, code, is_prime, count} !== {1'b1, 4'd15, 1'b0, 5'd1}) begin
      failures++;
      $display("FAIL stall_code15 got v=%b code=%0d p=%b cnt=%0d exp v=1 code=15 p=0 cnt=1",
               out_valid, code, is_prime, count);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL stall_idle got v=%b b=%b exp 0 0", out_valid, busy);
    end
  endtask

  task automatic test_none();
    load = 1'b1; req = 16'h0000; out_ready = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if ({none, busy, out_valid} !== 3'b100) begin
      failures++;
      $display("FAIL none_pulse got n=%b b=%b v=%b exp n=1 b=0 v=0", none, busy, out_valid);
    end
    @(negedge clk);
    checks++;
    if ({none, busy, out_valid, count} !== 8'd0) begin
      failures++;
      $display("FAIL none_clear got n=%b b=%b v=%b cnt=%0d exp 0", none, busy, out_valid, count);
    end
  endtask

  task automatic test_ignore_load();
    load = 1'b1; req = 16'h0030; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, code, count} !== {1'b1, 4'd4, 5'd2}) begin
      failures++;
      $display("FAIL ignore_code4 got v=%b code=%0d cnt=%0d exp v=1 code=4 cnt=2", out_valid, code, count);
    end
    load = 1'b1; req = 16'h0001;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if ({out_valid, code, is_prime, count} !== {1'b1, 4'd5, 1'b1, 5'd1}) begin
      failures++;
      $display("FAIL ignore_code5 got v=%b code=%0d p=%b cnt=%0d exp v=1 code=5 p=1 cnt=1",
               out_valid, code, is_prime, count);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, busy, count} !== 7'd0) begin
      failures++;
      $display("FAIL ignore_idle got v=%b b=%b cnt=%0d exp 0", out_valid, busy, count);
    end
  endtask

  task automatic test_reset_mid();
    load = 1'b1; req = 16'hFFFF; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load = 1'b0;
      checks++;
      if ({out_valid, code, count} !== {1'b1, 4'(i), 5'(16 - i)}) begin
        failures++;
        $display("FAIL full_step%0d got v=%b code=%0d cnt=%0d exp v=1 code=%0d cnt=%0d",
                 i, out_valid, code, count, i, 16 - i);
      end
    end
    rst_n = 1'b0; load = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; load = 1'b0;
    checks++;
    if ({out_valid, busy, count, code} !== 11'd0) begin
      failures++;
      $display("FAIL midreset got v=%b b=%b cnt=%0d code=%0d exp 0", out_valid, busy, count, code);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, busy, count} !== 7'd0) begin
        failures++;
        $display("FAIL midreset_quiet%0d got v=%b b=%b cnt=%0d exp 0", i, out_valid, busy, count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_primes();
    test_stall();
    test_none();
    test_ignore_load();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priority_encoder_16_4_seq.md
PRIORITY_ENCODER_16_4_SEQ -- requirements
Module: priority_encoder_16_4_seq

Interface
REQ-001 Parameter PRIME_MASK, default 16'h28AC, one bit per index, set for the prime indices 2, 3, 5, 7, 11 and 13.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
REQ-004 req  input  16  request lines d0..d15; bit k is request for index k.
REQ-005 load  input  1  capture strobe for req; honoured only in IDLE.
REQ-006 out_ready  input  1  consumer accepts the current code when high.
REQ-007 code  output  4  binary index of the lowest pending request.
REQ-008 out_valid  output  1  code and is_prime are valid.
REQ-009 is_prime  output  1  PRIME_MASK[code] while out_valid is high, else 0.
REQ-010 busy  output  1  high while in state EMIT.
REQ-011 none  output  1  one-cycle pulse for a load with req == 0.
REQ-012 count  output  5  number of pending requests, 0..16.

Function
REQ-013 The block SHALL have two states, IDLE and EMIT, and a 16-bit pending register pend.
REQ-014 In IDLE, load=1 with req!=0 SHALL capture pend<=req and enter EMIT on the same edge.
REQ-015 In IDLE, load=1 with req==0 SHALL pulse none=1 for exactly the following cycle, leave pend=0 and stay in IDLE.
REQ-016 In IDLE with load=0, no state SHALL change and none SHALL be 0.
REQ-017 Latency: load sampled at edge N SHALL produce out_valid=1 in the cycle after edge N.
REQ-018 In EMIT, out_valid SHALL be 1 and code SHALL equal the index of the lowest set bit of pend.
REQ-019 code, is_prime, out_valid, busy and count SHALL derive only from registers, with no combinational path from any input.
REQ-020 A handshake SHALL occur at an edge where out_valid and out_ready are both 1; that edge SHALL clear pend[code].
REQ-021 If the handshake clears the last pending bit, the block SHALL return to IDLE on that edge: out_valid=0 and busy=0 in the next cycle.
REQ-022 Otherwise, the next cycle's code SHALL be the next-lowest pending index, so out_ready held high gives one code per cycle.
REQ-023 With out_valid=1 and out_ready=0, code, is_prime and count SHALL stay stable.
REQ-024 In EMIT, load and req SHALL be ignored and pend SHALL change only through REQ-020.
REQ-025 count SHALL equal the popcount of pend and decrement by 1 per handshake.
REQ-026 In IDLE, code=0, is_prime=0, out_valid=0 and count=0.
REQ-027 Index 15 and req=16'hFFFF (count=16) SHALL be handled with no overflow or wrap of code or count.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force the IDLE state, pend=0 and all outputs to 0 in the next cycle, regardless of state.
REQ-029 Reset in mid-EMIT SHALL discard all pending requests; no code SHALL be emitted after reset until a new load.
REQ-030 rst_n=0 SHALL take priority over load and over any handshake sampled at the same edge.

Verification
REQ-031 load, req=16'h0001, out_ready=1 -> next cycle out_valid=1, code=0, is_prime=0, count=1; cycle after: out_valid=0, busy=0.
REQ-032 load, req=16'h28AC, out_ready held 1 -> codes 2,3,5,7,11,13 on six consecutive cycles, is_prime=1 each, count 6..1, then IDLE.
REQ-033 load, req=16'h8001, out_ready=0 for 3 cycles -> code=0 stable for 3 cycles; out_ready=1 -> code 15, is_prime=0, then IDLE.
REQ-034 load with req=16'h0000 -> none=1 for one cycle; busy=0, out_valid=0 throughout.
REQ-035 During EMIT of 16'h0030, load with req=16'h0001 -> ignored; codes 4 then 5 only.
REQ-036 load req=16'hFFFF, out_ready=1, rst_n=0 after codes 0..3 -> next cycle out_valid=0, count=0, busy=0; no further codes.
